// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Optional forwarding outputs are enabled by RF_WB_BYPASS_EN.
package rf_arb_pkg;

   typedef enum logic {ARB_NORMAL, ARB_FORCE_B} arb_state_t;

   localparam int NUM_REGS  = 32;
   localparam int REG_ADR_W = 5;
   localparam int WAIT_W    = 4;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard for long-latency MDU writes.
// Bit 0 never reads busy; a set wins over a same-cycle clear.
module rf_scoreboard
   import rf_arb_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 set_en,
   input  logic [REG_ADR_W-1:0] set_adr,
   input  logic                 clr_en,
   input  logic [REG_ADR_W-1:0] clr_adr,
   input  logic [REG_ADR_W-1:0] rs1_adr,
   input  logic [REG_ADR_W-1:0] rs2_adr,
   input  logic                 rs1_kill,
   input  logic                 rs2_kill,
   output logic                 rs1_busy,
   output logic                 rs2_busy
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      if (clr_en) begin
         busy_d[clr_adr] = 1'b0;
      end
      if (set_en && (set_adr != '0)) begin
         busy_d[set_adr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign rs1_busy = ~rst & busy_q[rs1_adr] & ~rs1_kill;
   assign rs2_busy = ~rst & busy_q[rs2_adr] & ~rs2_kill;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between writeback (A) and MDU (B).
// Define RF_WB_BYPASS_EN to add same-cycle forwarding of the written value.
module regfile_wb_arbiter
   import rf_arb_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 A_VALID,
   input  logic [REG_ADR_W-1:0] A_ADR,
   input  logic [XLEN-1:0]      A_DATA,
   output logic                 A_STALL,
   input  logic                 B_VALID,
   input  logic [REG_ADR_W-1:0] B_ADR,
   input  logic [XLEN-1:0]      B_DATA,
   output logic                 B_READY,
   input  logic                 ISSUE_VALID,
   input  logic [REG_ADR_W-1:0] ISSUE_RD,
   input  logic [REG_ADR_W-1:0] RS1_ADR,
   input  logic [REG_ADR_W-1:0] RS2_ADR,
`ifdef RF_WB_BYPASS_EN
   output logic                 RS1_FWD,
   output logic                 RS2_FWD,
   output logic [XLEN-1:0]      RS1_FWD_DATA,
   output logic [XLEN-1:0]      RS2_FWD_DATA,
`endif
   output logic                 RS1_BUSY,
   output logic                 RS2_BUSY,
   output logic                 REG_EN,
   output logic [REG_ADR_W-1:0] REG_W_ADR,
   output logic [XLEN-1:0]      REG_W_DATA
);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   arb_state_t        state_q;
   arb_state_t        state_d;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic [WAIT_W-1:0] wait_cnt_d;

   logic grant_a;
   logic grant_b;
   logic a_stall;
   logic rs1_kill;
   logic rs2_kill;

   always_comb begin
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      a_stall    = 1'b0;
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         ARB_NORMAL: begin
            grant_a = A_VALID;
            grant_b = B_VALID & ~A_VALID;
            if (A_VALID && B_VALID) begin
               if (wait_cnt_q == WAIT_LAST) begin
                  state_d    = ARB_FORCE_B;
                  wait_cnt_d = '0;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_ONE;
               end
            end else begin
               wait_cnt_d = '0;
            end
         end
         ARB_FORCE_B: begin
            // B normally still valid here; if it dropped, let A through
            grant_b    = B_VALID;
            grant_a    = A_VALID & ~B_VALID;
            a_stall    = A_VALID & B_VALID;
            state_d    = ARB_NORMAL;
            wait_cnt_d = '0;
         end
         default: begin
            state_d    = ARB_NORMAL;
            wait_cnt_d = '0;
         end
      endcase
      if (RST) begin
         grant_a = 1'b0;
         grant_b = 1'b0;
         a_stall = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ARB_NORMAL;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      REG_EN     = 1'b0;
      REG_W_ADR  = '0;
      REG_W_DATA = '0;
      if (grant_b) begin
         REG_EN     = (B_ADR != '0);
         REG_W_ADR  = B_ADR;
         REG_W_DATA = B_DATA;
      end else if (grant_a) begin
         REG_EN     = (A_ADR != '0);
         REG_W_ADR  = A_ADR;
         REG_W_DATA = A_DATA;
      end
   end

   assign A_STALL = a_stall;
   assign B_READY = grant_b;

`ifdef RF_WB_BYPASS_EN
   assign RS1_FWD      = REG_EN && (REG_W_ADR == RS1_ADR);
   assign RS2_FWD      = REG_EN && (REG_W_ADR == RS2_ADR);
   assign RS1_FWD_DATA = RS1_FWD ? REG_W_DATA : '0;
   assign RS2_FWD_DATA = RS2_FWD ? REG_W_DATA : '0;
   assign rs1_kill     = RS1_FWD & grant_b;
   assign rs2_kill     = RS2_FWD & grant_b;
`else
   assign rs1_kill = 1'b0;
   assign rs2_kill = 1'b0;
`endif

   rf_scoreboard u_sb (
      .clk      (CLK),
      .rst      (RST),
      .set_en   (ISSUE_VALID),
      .set_adr  (ISSUE_RD),
      .clr_en   (grant_b),
      .clr_adr  (B_ADR),
      .rs1_adr  (RS1_ADR),
      .rs2_adr  (RS2_ADR),
      .rs1_kill (rs1_kill),
      .rs2_kill (rs2_kill),
      .rs1_busy (RS1_BUSY),
      .rs2_busy (RS2_BUSY)
   );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Bypass checks are included when RF_WB_BYPASS_EN is defined.
module tb_regfile_wb_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        A_VALID;
   logic [4:0]  A_ADR;
   logic [31:0] A_DATA;
   logic        A_STALL;
   logic        B_VALID;
   logic [4:0]  B_ADR;
   logic [31:0] B_DATA;
   logic        B_READY;
   logic        ISSUE_VALID;
   logic [4:0]  ISSUE_RD;
   logic [4:0]  RS1_ADR;
   logic [4:0]  RS2_ADR;
   logic        RS1_BUSY;
   logic        RS2_BUSY;
   logic        REG_EN;
   logic [4:0]  REG_W_ADR;
   logic [31:0] REG_W_DATA;
`ifdef RF_WB_BYPASS_EN
   logic        RS1_FWD;
   logic        RS2_FWD;
   logic [31:0] RS1_FWD_DATA;
   logic [31:0] RS2_FWD_DATA;
`endif

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   regfile_wb_arbiter #(.XLEN(32), .MAX_WAIT(4)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .A_VALID     (A_VALID),
      .A_ADR       (A_ADR),
      .A_DATA      (A_DATA),
      .A_STALL     (A_STALL),
      .B_VALID     (B_VALID),
      .B_ADR       (B_ADR),
      .B_DATA      (B_DATA),
      .B_READY     (B_READY),
      .ISSUE_VALID (ISSUE_VALID),
      .ISSUE_RD    (ISSUE_RD),
      .RS1_ADR     (RS1_ADR),
      .RS2_ADR     (RS2_ADR),
`ifdef RF_WB_BYPASS_EN
      .RS1_FWD     (RS1_FWD),
      .RS2_FWD     (RS2_FWD),
      .RS1_FWD_DATA(RS1_FWD_DATA),
      .RS2_FWD_DATA(RS2_FWD_DATA),
`endif
      .RS1_BUSY    (RS1_BUSY),
      .RS2_BUSY    (RS2_BUSY),
      .REG_EN      (REG_EN),
      .REG_W_ADR   (REG_W_ADR),
      .REG_W_DATA  (REG_W_DATA)
   );

   task automatic idle();
      A_VALID     = 1'b0;
      A_ADR       = '0;
      A_DATA      = '0;
      B_VALID     = 1'b0;
      B_ADR       = '0;
      B_DATA      = '0;
      ISSUE_VALID = 1'b0;
      ISSUE_RD    = '0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      idle();
      RS1_ADR = '0;
      RS2_ADR = '0;
      @(negedge CLK);
      A_VALID = 1'b1; A_ADR = 5'd2; B_VALID = 1'b1; B_ADR = 5'd3;
      #1;
      checks++; if (REG_EN !== 1'b0) begin errors++; $display("FAIL rst_en: got %b exp 0", REG_EN); end
      checks++; if (B_READY !== 1'b0) begin errors++; $display("FAIL rst_bready: got %b exp 0", B_READY); end
      checks++; if (A_STALL !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", A_STALL); end
      @(negedge CLK);
      RST = 1'b0;
      idle();
      #1;
      checks++; if (REG_EN !== 1'b0) begin errors++; $display("FAIL idle_en: got %b exp 0", REG_EN); end
      checks++; if (REG_W_ADR !== 5'd0) begin errors++; $display("FAIL idle_adr: got %0d exp 0", REG_W_ADR); end
      checks++; if (REG_W_DATA !== 32'd0) begin errors++; $display("FAIL idle_data: got %h exp 0", REG_W_DATA); end
      checks++; if (RS1_BUSY !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b exp 0", RS1_BUSY); end
   endtask

   task automatic test_a_write();
      @(negedge CLK);
      idle();
      A_VALID = 1'b1; A_ADR = 5'd5; A_DATA = 32'hDEADBEEF;
      #1;
      checks++; if (REG_EN !== 1'b1) begin errors++; $display("FAIL a_en: got %b exp 1", REG_EN); end
      checks++; if (REG_W_ADR !== 5'd5) begin errors++; $display("FAIL a_adr: got %0d exp 5", REG_W_ADR); end
      checks++; if (REG_W_DATA !== 32'hDEADBEEF) begin errors++; $display("FAIL a_data: got %h exp deadbeef", REG_W_DATA); end
      checks++; if (A_STALL !== 1'b0) begin errors++; $display("FAIL a_stall: got %b exp 0", A_STALL); end
      @(negedge CLK);
      idle();
      B_VALID = 1'b1; B_ADR = 5'd6; B_DATA = 32'h0000_1234;
      #1;
      checks++; if (B_READY !== 1'b1) begin errors++; $display("FAIL b_only_ready: got %b exp 1", B_READY); end
      checks++; if (REG_W_DATA !== 32'h1234) begin errors++; $display("FAIL b_only_data: got %h exp 1234", REG_W_DATA); end
   endtask

   task automatic test_starvation();
      @(negedge CLK);
      idle();
      #1;
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) @(negedge CLK);
         A_VALID = 1'b1; A_ADR = 5'd4; A_DATA = 32'hA0A0_0000 + c;
         B_VALID = 1'b1; B_ADR = 5'd7; B_DATA = 32'hB0B0_B0B0;
         #1;
         if (c == 5) begin
            checks++; if (REG_W_ADR !== 5'd7) begin errors++; $display("FAIL force_adr c%0d: got %0d exp 7", c, REG_W_ADR); end
            checks++; if (REG_W_DATA !== 32'hB0B0B0B0) begin errors++; $display("FAIL force_data c%0d: got %h exp b0b0b0b0", c, REG_W_DATA); end
            checks++; if (B_READY !== 1'b1) begin errors++; $display("FAIL force_ready c%0d: got %b exp 1", c, B_READY); end
            checks++; if (A_STALL !== 1'b1) begin errors++; $display("FAIL force_stall c%0d: got %b exp 1", c, A_STALL); end
         end else begin
            checks++; if (REG_W_ADR !== 5'd4) begin errors++; $display("FAIL deny_adr c%0d: got %0d exp 4", c, REG_W_ADR); end
            checks++; if (B_READY !== 1'b0) begin errors++; $display("FAIL deny_ready c%0d: got %b exp 0", c, B_READY); end
            checks++; if (A_STALL !== 1'b0) begin errors++; $display("FAIL deny_stall c%0d: got %b exp 0", c, A_STALL); end
         end
      end
   endtask

   task automatic test_scoreboard();
      @(negedge CLK);
      idle();
      ISSUE_VALID = 1'b1; ISSUE_RD = 5'd9;
      @(negedge CLK);
      idle();
      RS1_ADR = 5'd9;
      #1;
      checks++; if (RS1_BUSY !== 1'b1) begin errors++; $display("FAIL sb_set: got %b exp 1", RS1_BUSY); end
      @(negedge CLK);
      B_VALID = 1'b1; B_ADR = 5'd9; B_DATA = 32'h99;
      #1;
      checks++; if (B_READY !== 1'b1) begin errors++; $display("FAIL sb_bready: got %b exp 1", B_READY); end
      @(negedge CLK);
      idle();
      #1;
      checks++; if (RS1_BUSY !== 1'b0) begin errors++; $display("FAIL sb_clr: got %b exp 0", RS1_BUSY); end
      @(negedge CLK);
      ISSUE_VALID = 1'b1; ISSUE_RD = 5'd9;
      B_VALID = 1'b1; B_ADR = 5'd9; B_DATA = 32'h77;
      @(negedge CLK);
      idle();
      #1;
      checks++; if (RS1_BUSY !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b exp 1", RS1_BUSY); end
      @(negedge CLK);
      B_VALID = 1'b1; B_ADR = 5'd9;
      @(negedge CLK);
      idle();
      #1;
      checks++; if (RS1_BUSY !== 1'b0) begin errors++; $display("FAIL sb_clr2: got %b exp 0", RS1_BUSY); end
   endtask

   task automatic test_x0();
      @(negedge CLK);
      idle();
      A_VALID = 1'b1; A_ADR = 5'd0; A_DATA = 32'h5555_AAAA;
      ISSUE_VALID = 1'b1; ISSUE_RD = 5'd0;
      #1;
      checks++; if (REG_EN !== 1'b0) begin errors++; $display("FAIL x0_a_en: got %b exp 0", REG_EN); end
      checks++; if (A_STALL !== 1'b0) begin errors++; $display("FAIL x0_a_stall: got %b exp 0", A_STALL); end
      @(negedge CLK);
      idle();
      RS1_ADR = 5'd0;
      B_VALID = 1'b1; B_ADR = 5'd0; B_DATA = 32'h1;
      #1;
      checks++; if (RS1_BUSY !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b exp 0", RS1_BUSY); end
      checks++; if (B_READY !== 1'b1) begin errors++; $display("FAIL x0_b_ready: got %b exp 1", B_READY); end
      checks++; if (REG_EN !== 1'b0) begin errors++; $display("FAIL x0_b_en: got %b exp 0", REG_EN); end
   endtask

   task automatic test_reset_in_force();
      @(negedge CLK);
      idle();
      ISSUE_VALID = 1'b1; ISSUE_RD = 5'd3;
      for (int c = 1; c <= 5; c++) begin
         @(negedge CLK);
         idle();
         RS2_ADR = 5'd3;
         A_VALID = 1'b1; A_ADR = 5'd1; A_DATA = 32'h11;
         B_VALID = 1'b1; B_ADR = 5'd7; B_DATA = 32'h77;
         #1;
         if (c == 1) begin
            checks++; if (RS2_BUSY !== 1'b1) begin errors++; $display("FAIL rf_busy3: got %b exp 1", RS2_BUSY); end
         end
      end
      checks++; if (A_STALL !== 1'b1) begin errors++; $display("FAIL rf_in_force: got %b exp 1", A_STALL); end
      RST = 1'b1;
      #1;
      checks++; if (REG_EN !== 1'b0) begin errors++; $display("FAIL rf_rst_en: got %b exp 0", REG_EN); end
      checks++; if (B_READY !== 1'b0) begin errors++; $display("FAIL rf_rst_ready: got %b exp 0", B_READY); end
      checks++; if (A_STALL !== 1'b0) begin errors++; $display("FAIL rf_rst_stall: got %b exp 0", A_STALL); end
      checks++; if (RS2_BUSY !== 1'b0) begin errors++; $display("FAIL rf_rst_busy: got %b exp 0", RS2_BUSY); end
      @(negedge CLK);
      RST = 1'b0;
      #1;
      checks++; if (REG_W_ADR !== 5'd1) begin errors++; $display("FAIL rf_post_adr: got %0d exp 1", REG_W_ADR); end
      checks++; if (B_READY !== 1'b0) begin errors++; $display("FAIL rf_post_ready: got %b exp 0", B_READY); end
      checks++; if (RS2_BUSY !== 1'b0) begin errors++; $display("FAIL rf_post_busy: got %b exp 0", RS2_BUSY); end
      @(negedge CLK);
      idle();
   endtask

`ifdef RF_WB_BYPASS_EN
   task automatic test_bypass();
      @(negedge CLK);
      idle();
      ISSUE_VALID = 1'b1; ISSUE_RD = 5'd3;
      @(negedge CLK);
      idle();
      RS1_ADR = 5'd4; RS2_ADR = 5'd3;
      B_VALID = 1'b1; B_ADR = 5'd3; B_DATA = 32'hCAFE_F00D;
      #1;
      checks++; if (RS2_FWD !== 1'b1) begin errors++; $display("FAIL byp_fwd: got %b exp 1", RS2_FWD); end
      checks++; if (RS2_FWD_DATA !== 32'hCAFEF00D) begin errors++; $display("FAIL byp_data: got %h exp cafef00d", RS2_FWD_DATA); end
      checks++; if (RS2_BUSY !== 1'b0) begin errors++; $display("FAIL byp_busy: got %b exp 0", RS2_BUSY); end
      checks++; if (RS1_FWD !== 1'b0) begin errors++; $display("FAIL byp_rs1: got %b exp 0", RS1_FWD); end
      @(negedge CLK);
      idle();
   endtask
`endif

   initial begin
      test_reset();
      test_a_write();
      test_starvation();
      test_scoreboard();
      test_x0();
      test_reset_in_force();
`ifdef RF_WB_BYPASS_EN
      test_bypass();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file, which writes on the falling edge.
- Shares that port between two requesters:
  - Port A: the in-order pipeline writeback stage.
  - Port B: the long-latency multiply/divide unit (MDU) with a valid/ready handshake.
- Keeps a pending-destination scoreboard so decode can stall on registers the MDU has yet to write.

Parameters:
- XLEN, 32, data width.
- MAX_WAIT, 4, number of consecutive cycles B may be denied before it is forced through (range 1..15).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- A_VALID  in  1  writeback stage has a result.
- A_ADR  in  5  writeback destination.
- A_DATA  in  XLEN  writeback data.
- A_STALL  out  1  holds the writeback stage; A must keep A_ADR/A_DATA stable.
- B_VALID  in  1  MDU result available.
- B_ADR  in  5  MDU destination.
- B_DATA  in  XLEN  MDU data.
- B_READY  out  1  B result accepted this cycle.
- ISSUE_VALID  in  1  decode dispatches an op to the MDU.
- ISSUE_RD  in  5  destination of the dispatched op.
- RS1_ADR  in  5  decode source 1 query.
- RS2_ADR  in  5  decode source 2 query.
- RS1_BUSY  out  1  RS1_ADR has a pending MDU write.
- RS2_BUSY  out  1  RS2_ADR has a pending MDU write.
- REG_EN  out  1  register-file write enable.
- REG_W_ADR  out  5  register-file write address.
- REG_W_DATA  out  XLEN  register-file write data.

Behaviour:
- Write-port grant is combinational; scoreboard and arbitration state are registered. The write lands on the negedge of the grant cycle.
- States:
  - NORMAL: fixed priority to A.
    - If A_VALID, A is granted.
    - If B_VALID and not A_VALID, B is granted and B_READY=1.
    - If B is denied (B_VALID=1, A granted), wait_cnt increments.
    - When wait_cnt==MAX_WAIT-1 and B is denied again, go to FORCE_B.
  - FORCE_B: B is granted and B_READY=1.
    - If A_VALID, A_STALL=1 and A is not written.
    - Next state is NORMAL; wait_cnt clears.
- wait_cnt clears on any B grant and whenever B_VALID=0.
- A_STALL is 0 in NORMAL.
- REG_EN=granted requester valid AND granted address !=0.
  - A write to x0 is consumed (B_READY=1 / no stall) but REG_EN stays 0.
  - REG_W_ADR/REG_W_DATA follow the granted port, and are 0 when idle.
- Scoreboard: 32-bit busy vector; bit 0 is hard-wired 0.
  - Set on ISSUE_VALID for ISSUE_RD != 0.
  - Cleared when B is granted for B_ADR.
  - Set and clear of the same register in the same cycle: set wins, because a new op is pending.
- RSn_BUSY=busy[RSn_ADR], combinational from the registered vector.
- Reset, including mid-operation: state=NORMAL, wait_cnt=0, busy=0. While RST=1: REG_EN=0, B_READY=0, A_STALL=0, RS*_BUSY=0.
- A in-flight B result is dropped on reset; the MDU is reset by the same RST.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- When defined, add outputs:
  - RS1_FWD, RS2_FWD (1 bit each).
  - RS1_FWD_DATA, RS2_FWD_DATA (XLEN each).
- RSn_FWD=REG_EN && REG_W_ADR==RSn_ADR. FWD_DATA=REG_W_DATA, else 0.
- With the bypass, RSn_BUSY is suppressed when RSn_FWD is set by a B write.
- When not defined: the ports are absent and busy is reported purely from the registered vector.

Decomposition:
- Package rf_arb_pkg:
  - typedef enum logic {ARB_NORMAL, ARB_FORCE_B} arb_state_t.
  - localparam NUM_REGS=32.
  - localparam REG_ADR_W=5.
- One natural sub-module: rf_scoreboard, holding the busy vector, set/clear logic and the two query ports. The arbiter FSM stays in the top.

Test Plan:
1. A_VALID=1, A_ADR=5, A_DATA=0xDEADBEEF; B idle -> REG_EN=1, REG_W_ADR=5, REG_W_DATA=0xDEADBEEF, A_STALL=0.
2. A_VALID and B_VALID (B_ADR=7) held continuously, MAX_WAIT=4 -> B denied for 4 cycles. Cycle 5: FORCE_B, REG_W_ADR=7, B_READY=1, A_STALL=1. Cycle 6: A granted again.
3. ISSUE_VALID, ISSUE_RD=9 -> next cycle RS1_ADR=9 gives RS1_BUSY=1. A later B write to 9 -> RS1_BUSY=0 the cycle after.
4. Same cycle ISSUE_RD=9 and B grant to 9 -> busy[9] remains 1.
5. A_ADR=0 with A_VALID=1, and ISSUE_RD=0 -> REG_EN=0, busy[0]=0, no stall.
6. RST asserted in FORCE_B with busy[3]=1 -> next cycle NORMAL, all busy 0, REG_EN=0. With RF_WB_BYPASS_EN: a B write to 3 while RS2_ADR=3 -> RS2_FWD=1, RS2_FWD_DATA=B_DATA, RS2_BUSY=0.
